// File: rtl/keypad_pkg.sv
// keypad_pkg: key map and state encoding shared by the keypad emulator and the keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_IN  = 3'd1,
        HELD       = 3'd2,
        BOUNCE_OUT = 3'd3,
        GAP        = 3'd4
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef struct packed {
        logic       none;
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Digits 1-9 fill rows 0-2 left to right; the bottom row is * 0 #.
    function automatic key_pos_t key_map(input logic [3:0] code);
        key_pos_t p;
        logic [3:0] k;
        p = '0;
        k = code - 4'd1;
        if (code != 4'd0 && code < KEY_STAR) begin
            p.row = 2'(k / 4'd3);
            p.col = 2'(k % 4'd3);
        end else if (code == 4'd0) begin
            p.row = 2'd3;
            p.col = 2'd1;
        end else if (code == KEY_STAR) begin
            p.row = 2'd3;
            p.col = 2'd0;
        end else if (code == KEY_HASH) begin
            p.row = 2'd3;
            p.col = 2'd2;
        end else begin
            p.none = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: valid/ready key-press request port with sequence status.
interface keypad_emulator_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       busy;
    logic       done;

    modport master (output key_valid, key_code, input key_ready, busy, done);
    modport slave  (input key_valid, key_code, output key_ready, busy, done);
endinterface

// File: rtl/keypad_emulator_bounce_gen.sv
// bounce_gen: contact chatter source, toggles every PERIOD cycles from start_level over a WIN-cycle window.
module bounce_gen #(
    parameter int unsigned WIN    = 64,
    parameter int unsigned PERIOD = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    input  logic start_level,
    output logic level,
    output logic last
);
    localparam logic [31:0] WIN_M1 = WIN - 1;
    localparam logic [31:0] PER_M1 = PERIOD - 1;

    logic [31:0] ph;
    logic [31:0] wc;

    assign last = wc == 32'd0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level <= 1'b0;
            ph    <= '0;
            wc    <= '0;
        end else if (start) begin
            level <= start_level;
            ph    <= PER_M1;
            wc    <= WIN_M1;
        end else begin
            wc    <= wc - 32'(wc != 32'd0);
            level <= (ph == 32'd0) ? ~level : level;
            ph    <= (ph == 32'd0) ? PER_M1 : ph - 32'd1;
        end
    end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: stands in for a 3x4 matrix keypad, pressing scripted keys with contact bounce.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned GAP_CYCLES    = 1000,
    parameter int unsigned BOUNCE_CYCLES = 64,
    parameter int unsigned BOUNCE_PERIOD = 8
) (
    input  logic CLK,
    input  logic RST,
    keypad_emulator_if.slave req,
    input  logic B,
    input  logic G,
    input  logic F,
    input  logic D,
    output logic C,
    output logic A,
    output logic E
);
    localparam bit          NB      = BOUNCE_CYCLES == 0;
    localparam logic [31:0] HOLD_M1 = HOLD_CYCLES - 1;
    localparam logic [31:0] GAP_M1  = GAP_CYCLES - 1;

    state_t      state;
    logic [31:0] cnt;
    key_pos_t    key;
    logic        done;
    logic        accept;
    logic        contact;
    logic        hit;
    logic        bg_start;
    logic        bg_level;
    logic        bg_last;
    logic [3:0]  rows;

    assign req.key_ready = state == IDLE;
    assign req.busy      = state != IDLE;
    assign req.done      = done;
    assign accept        = req.key_valid && req.key_ready;
    assign bg_start      = !NB && (accept || (state == HELD && cnt == 32'd0));

    bounce_gen #(.WIN(BOUNCE_CYCLES), .PERIOD(BOUNCE_PERIOD)) u_bounce (
        .CLK(CLK),
        .RST(RST),
        .start(bg_start),
        .start_level(state == IDLE),
        .level(bg_level),
        .last(bg_last)
    );

    // The switch itself: rows pass straight through to the selected column while closed.
    assign contact = (state == HELD) || ((state == BOUNCE_IN || state == BOUNCE_OUT) && bg_level);
    assign rows    = {D, F, G, B};
    assign hit     = contact && !key.none && rows[key.row];
    assign C       = hit && key.col == 2'd0;
    assign A       = hit && key.col == 2'd1;
    assign E       = hit && key.col == 2'd2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            key   <= '0;
            done  <= 1'b0;
        end else begin
            done <= state == GAP && cnt == 32'd0;
            case (state)
                IDLE: if (accept) begin
                    key   <= key_map(req.key_code);
                    state <= NB ? HELD : BOUNCE_IN;
                    cnt   <= HOLD_M1;
                end
                BOUNCE_IN: if (bg_last) begin
                    state <= HELD;
                    cnt   <= HOLD_M1;
                end
                HELD: begin
                    state <= (cnt == 32'd0) ? (NB ? GAP : BOUNCE_OUT) : HELD;
                    cnt   <= (cnt == 32'd0) ? GAP_M1 : cnt - 32'd1;
                end
                BOUNCE_OUT: if (bg_last) begin
                    state <= GAP;
                    cnt   <= GAP_M1;
                end
                GAP: begin
                    state <= (cnt == 32'd0) ? IDLE : GAP;
                    cnt   <= cnt - 32'(cnt != 32'd0);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of a default emulator and a fast no-bounce emulator.
module tb_keypad_emulator;

    typedef struct {
        logic [3:0] code;
        logic [3:0] rows;
        logic [2:0] cols;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] rows = 4'b0000;
    logic       B, G, F, D;
    logic       c0, a0, e0, c1, a1, e1;
    int         nv = 0;
    int         nf = 0;
    vec_t       tv [15];

    assign {D, F, G, B} = rows;

    always #5 CLK = ~CLK;

    keypad_emulator_if if0 ();
    keypad_emulator_if if1 ();

    keypad_emulator dut0 (
        .CLK(CLK), .RST(RST), .req(if0),
        .B(B), .G(G), .F(F), .D(D),
        .C(c0), .A(a0), .E(e0)
    );

    keypad_emulator #(
        .HOLD_CYCLES(4), .GAP_CYCLES(3), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(8)
    ) dut1 (
        .CLK(CLK), .RST(RST), .req(if1),
        .B(B), .G(G), .F(F), .D(D),
        .C(c1), .A(a1), .E(e1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nv++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One full default-timing press on dut0: bounce windows, hold, release, gap, done.
    task automatic seq0(input logic [3:0] code, input logic [3:0] r, input logic [2:0] ex, input bit poke);
        int pw, rw, tot, bad, dl, nd;
        logic [2:0] c, prev;
        pw = 0; rw = 0; tot = 0; bad = 0; dl = 0; nd = 0;
        prev = 3'b000;
        @(negedge CLK);
        chk("ready0 before press", 32'(if0.key_ready), 1);
        rows = r;
        if0.key_code = code;
        if0.key_valid = 1'b1;
        @(posedge CLK);
        #1 if0.key_valid = 1'b0;
        for (int n = 1; n <= 2140; n++) begin
            @(negedge CLK);
            c = {c0, a0, e0};
            if (c != prev) begin
                tot++;
                if (n <= 64) pw++;
                if (n >= 1065 && n <= 1128) rw++;
            end
            prev = c;
            if (n >= 65 && n <= 1064 && c != ex) bad++;
            if (if0.done) begin
                nd++;
                if (dl == 0) dl = n;
            end
            if (n == 1) begin
                chk("busy0 after accept", 32'(if0.busy), 1);
                chk("ready0 after accept", 32'(if0.key_ready), 0);
            end
            if (poke && n == 500) begin
                rows = 4'b0001;
                #1 chk("wrong row driven", 32'({c0, a0, e0}), 0);
                rows = r;
                #1;
            end
            if (poke && n == 1500) begin
                if0.key_code = 4'd1;
                if0.key_valid = 1'b1;
            end
            if (poke && n == 1501) if0.key_valid = 1'b0;
        end
        chk("press bounce transitions", pw, (ex != 0) ? 8 : 0);
        chk("release bounce transitions", rw, (ex != 0) ? 8 : 0);
        chk("total transitions", tot, (ex != 0) ? 18 : 0);
        chk("held cols bad cycles", bad, 0);
        chk("done latency", dl, 2129);
        chk("done pulse count", nd, 1);
        chk("busy0 after done", 32'(if0.busy), 0);
    endtask

    initial begin
        int hi, dl, d1, d2, nd;
        logic [2:0] c;
        tv[0]  = '{4'd1,  4'b0001, 3'b100};
        tv[1]  = '{4'd2,  4'b0001, 3'b010};
        tv[2]  = '{4'd3,  4'b0001, 3'b001};
        tv[3]  = '{4'd4,  4'b0010, 3'b100};
        tv[4]  = '{4'd5,  4'b0010, 3'b010};
        tv[5]  = '{4'd5,  4'b0001, 3'b000};
        tv[6]  = '{4'd9,  4'b0100, 3'b001};
        tv[7]  = '{4'd7,  4'b1111, 3'b100};
        tv[8]  = '{4'd0,  4'b1000, 3'b010};
        tv[9]  = '{4'd10, 4'b1000, 3'b100};
        tv[10] = '{4'd11, 4'b1000, 3'b001};
        tv[11] = '{4'd11, 4'b0010, 3'b000};
        tv[12] = '{4'd12, 4'b1111, 3'b000};
        tv[13] = '{4'd15, 4'b1111, 3'b000};
        tv[14] = '{4'd8,  4'b0000, 3'b000};
        if0.key_valid = 1'b0; if0.key_code = 4'd0;
        if1.key_valid = 1'b0; if1.key_code = 4'd0;
        repeat (3) @(negedge CLK);
        rows = 4'b1111;
        #1;
        chk("reset ready0", 32'(if0.key_ready), 1);
        chk("reset busy0", 32'(if0.busy), 0);
        chk("reset done0", 32'(if0.done), 0);
        chk("reset cols0", 32'({c0, a0, e0}), 0);
        chk("reset ready1", 32'(if1.key_ready), 1);
        chk("reset cols1", 32'({c1, a1, e1}), 0);
        RST = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            chk("ready1 before press", 32'(if1.key_ready), 1);
            rows = tv[i].rows;
            if1.key_code = tv[i].code;
            if1.key_valid = 1'b1;
            @(posedge CLK);
            #1 if1.key_valid = 1'b0;
            hi = 0; dl = 0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge CLK);
                c = {c1, a1, e1};
                if (n == 1) begin
                    chk("fast cols", 32'(c), 32'(tv[i].cols));
                    chk("fast busy", 32'(if1.busy), 1);
                end
                if (c != 3'b000) hi++;
                if (if1.done && dl == 0) dl = n;
            end
            chk("fast hold length", hi, (tv[i].cols != 0) ? 4 : 0);
            chk("fast done latency", dl, 8);
        end

        // Request held through done is taken on the done cycle itself.
        @(negedge CLK);
        rows = 4'b1000;
        if1.key_code = 4'd11;
        if1.key_valid = 1'b1;
        @(posedge CLK);
        hi = 0; d1 = 0; d2 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (e1) hi++;
            if (if1.done) begin
                if (d1 == 0) d1 = n;
                else if (d2 == 0) d2 = n;
            end
            if (n == 8) chk("b2b ready on done", 32'(if1.key_ready), 1);
            if (n == 9) chk("b2b busy after done", 32'(if1.busy), 1);
            if (n == 16) if1.key_valid = 1'b0;
        end
        chk("b2b first done", d1, 8);
        chk("b2b second done", d2, 16);
        chk("b2b E cycles", hi, 8);

        seq0(4'd5, 4'b0010, 3'b010, 1'b1);
        seq0(4'd0, 4'b1000, 3'b010, 1'b0);
        seq0(4'd13, 4'b1111, 3'b000, 1'b0);

        // Reset in the middle of HELD aborts without a done.
        @(negedge CLK);
        rows = 4'b0010;
        if0.key_code = 4'd5;
        if0.key_valid = 1'b1;
        @(posedge CLK);
        #1 if0.key_valid = 1'b0;
        repeat (100) @(negedge CLK);
        chk("A during held", 32'(a0), 1);
        #1 RST = 1'b1;
        #1 chk("cols on reset", 32'({c0, a0, e0}), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("busy0 after reset", 32'(if0.busy), 0);
        chk("ready0 after reset", 32'(if0.key_ready), 1);
        nd = 0;
        for (int n = 0; n < 2200; n++) begin
            @(negedge CLK);
            if (if0.done) nd++;
        end
        chk("no done after reset", nd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end
endmodule
